// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU front end.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_READY  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Request/acknowledge instruction-memory port between the fetch stage and memory.
interface pc_fetch_stage_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface

// File: rtl/pc_fetch_stage_ack_timer.sv
// Counts FETCH cycles without an acknowledge; expired flags the last allowed cycle.
module ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and instruction-fetch sequencer: holds PC, fetches over a req/ack port,
// and handles halt, fetch timeout, misaligned targets and the retired counter.
module pc_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int                ACK_TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [WORD_W-1:0]   next_PC,
    input  logic                PCWre,
    input  logic                halt,
    pc_fetch_stage_if.master    imem,
    output logic [WORD_W-1:0]   PC,
    output logic [WORD_W-1:0]   PC4,
    output logic [WORD_W-1:0]   instr,
    output logic                instr_valid,
    output logic                halted,
    output logic                fetch_err,
    output logic [WORD_W-1:0]   retired
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] retired_q, retired_d;
    logic              req_q, req_d;

    logic fetch_active;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // The reset state is FETCH but the request only goes out once reset has released,
    // so acks and timeouts count only while the request is actually on the port.
    assign fetch_active = (state_q == ST_FETCH) && req_q;
    assign timer_clr    = !fetch_active || imem.imem_ack;
    assign timer_en     = fetch_active && !imem.imem_ack;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (CLK),
        .rst     (Reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // NOTE: every signal is given its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_FETCH: begin
                if (fetch_active) begin
                    if (imem.imem_ack) begin
                        instr_d = imem.imem_rdata;
                        state_d = ST_READY;
                    end else if (timer_expired) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_READY: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (PCWre) begin
                    if (is_word_aligned(next_PC)) begin
                        pc_d      = next_PC;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: begin
            end
        endcase

        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= req_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign PC          = pc_q;
    assign PC4         = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_READY);
    assign halted      = (state_q == ST_HALTED) || (state_q == ST_ERROR);
    assign fetch_err   = (state_q == ST_ERROR);
    assign retired     = retired_q;

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Program-counter register and instruction-fetch sequencer for the multi-cycle CPU. It holds the architectural PC and exports `PC4` to the next-PC selector. It captures the selector's `next_PC` when the control unit asserts `PCWre`, then fetches the instruction at the new PC over a request/acknowledge instruction-memory port. It also provides halt, fetch-timeout and misalignment error handling, plus a retired-instruction counter.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `ACK_TIMEOUT`, 16, number of FETCH cycles without `imem_ack` before a fetch error is raised; legal range 1–255.
- `CLK` in 1: single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `next_PC` in 32: candidate PC from the next-PC selector.
- `PCWre` in 1: control unit's PC write enable.
- `halt` in 1: halt request from the control unit.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `PC`.
- `imem_rdata` in 32: instruction word; valid only when `imem_ack` is 1.
- `imem_ack` in 1: fetch completion.
- `PC` out 32: current PC.
- `PC4` out 32: `PC + 4`, computed combinationally and truncated mod 2^32.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` corresponds to `PC`.
- `halted` out 1: block is stopped (halt or error).
- `fetch_err` out 1: sticky error flag.
- `retired` out 32: count of accepted PC updates; wraps mod 2^32.

## Operation
- **States:** FETCH, READY, HALTED, ERROR.
- **Reset:** state=FETCH, `PC`=`RESET_PC`, `instr`=0, `instr_valid`=0, `halted`=0, `fetch_err`=0, `retired`=0, internal timer=0.
- **FETCH:**
  - `imem_req`=1, `instr_valid`=0.
  - On `imem_ack`: `instr`<=`imem_rdata`, timer<=0, go to READY.
  - Without ack: timer increments. If timer reaches `ACK_TIMEOUT`-1 with no ack, go to ERROR.
  - If ack and timeout fall in the same cycle, ack wins.
  - `PCWre` and `halt` are ignored in FETCH.
- **READY:**
  - `imem_req`=0, `instr_valid`=1.
  - Priority: `halt` > `PCWre`.
  - `halt`=1: go to HALTED. `PC` and `instr` are unchanged.
  - `PCWre`=1 and `next_PC[1:0]`==0: `PC`<=`next_PC`, `retired`+=1, go to FETCH.
  - `PCWre`=1 and `next_PC[1:0]`!=0: go to ERROR. `PC` is unchanged and `retired` is not incremented.
  - Neither asserted: remain in READY and hold all outputs.
- **HALTED:** absorbing until `Reset`. `imem_req`=0, `instr_valid`=0, `halted`=1.
- **ERROR:** absorbing until `Reset`. `imem_req`=0, `instr_valid`=0, `halted`=1, `fetch_err`=1.
- **Late acks:** an `imem_ack` outside FETCH is ignored.
- **Reset mid-fetch:** `imem_req` drops in the cycle after `Reset` is sampled high. The block re-requests at `RESET_PC` once `Reset` falls; an ack in the reset cycle is discarded.

## Timing
- **Request timing:** `imem_req` is registered from state and rises in the first cycle after `Reset` deasserts.
- **Combinational memory:** `imem_ack` may be high in the same cycle as the request. Minimum throughput is then 2 cycles per instruction (FETCH, READY).
- **Address stability:** `imem_addr` is held stable for the whole time `imem_req`=1.
- **Update latency:** `PC` updates exactly one edge after `PCWre` is sampled in READY. `PC4` follows combinationally in the same cycle.
- **Valid latency:** `instr_valid` rises one edge after an ack and falls one edge after an accepted `PCWre` or `halt`.
- **Error timing:**
  - Timeout: with no ack, `fetch_err` asserts on the edge ending the `ACK_TIMEOUT`-th FETCH cycle.
  - Misalignment: `fetch_err` asserts one edge after the misaligned `PCWre`.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch-state enum (FETCH, READY, HALTED, ERROR);
  - the `RESET_PC` default;
  - a width constant `WORD_W`=32.
- One natural sub-module, `ack_timer`: an 8-bit counter with clear/enable and an `expired` output at `ACK_TIMEOUT`-1.
- The FSM, PC register, instruction latch and `retired` counter stay in `pc_fetch_stage`.

## Test plan
- **Reset and first fetch:** `Reset` for 2 cycles; memory acks immediately with 32'h2002_0005 → `imem_addr`=0, `instr`=32'h2002_0005, `instr_valid`=1 two cycles after `Reset` falls.
- **Sequential run with slow memory:** `PCWre` pulses with `next_PC`=`PC4`; ack 3 cycles late → `PC` steps 0, 4, 8, 12. `imem_addr` is stable during each request and `retired`=3.
- **Branch and jump targets:** `next_PC`=32'h0000_0040 then 32'h0040_0000 → `PC` loads each target; `PC4` = 32'h44, then 32'h0040_0004.
- **Halt priority:** `halt`=1 and `PCWre`=1 together in READY → `halted`=1, `PC` unchanged, `retired` unchanged, `imem_req` stays 0 thereafter.
- **Error paths:**
  - No ack for `ACK_TIMEOUT` cycles → `fetch_err`=1, `halted`=1.
  - Separately, `next_PC`=32'h0000_0006 → ERROR.
  - In both cases, a subsequent `Reset` clears everything and fetch restarts at `RESET_PC`.
- **Reset mid-fetch:** `Reset` during a pending request with a simultaneous ack → ack discarded, `instr`=0, fetch restarts at `RESET_PC`.
